id_hazard_ctrl: RTL and testbench

Issue controller for the decode stage of the FP-extended MIPS pipeline. Monitors the instruction in F/D and tracks what was just issued into D/X. Tracks one outstanding multi-cycle MUL.S. Produces the stall, bubble and flush controls that hold fetch/decode and insert NOPs into D/X. Sits beside the decode unit; its outputs gate the F/D register enable and the D/X control-field clear.

---
 rtl/id_hazard_ctrl_pkg.sv | 77 +++++++
 rtl/id_hazard_ctrl_if.sv | 27 ++
 rtl/id_reg_use_dec.sv | 27 ++
 rtl/id_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_id_hazard_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared decode constants and register-usage decode for the
// decode-stage issue controller.
package id_hazard_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_LWC1 = 6'd49;
    localparam logic [5:0] OP_SWC1 = 6'd57;
    localparam logic [5:0] OP_FPR  = 6'd17;

    localparam logic [5:0] FN_ADD_S = 6'd0;
    localparam logic [5:0] FN_MUL_S = 6'd2;

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } mul_state_e;

    // src_int: [0]=rs [1]=rt ; src_fp: [0]=fs [1]=ft
    typedef struct packed {
        logic [1:0] src_int;
        logic [1:0] src_fp;
        logic [4:0] dst;
        logic       dst_fp;
        logic       dst_v;
    } reg_use_t;

    function automatic reg_use_t decode_use(input logic [31:0] instr);
        reg_use_t   u;
        logic [5:0] op;
        op = instr[31:26];
        u  = '0;
        unique case (1'b1)
            (op == OP_R): begin
                u.src_int = 2'b11;
                u.dst     = instr[15:11];
                u.dst_v   = 1'b1;
            end
            (op == OP_SW), (op == OP_BEQ), (op == OP_BNE): begin
                u.src_int = 2'b11;
            end
            (op == OP_ADDI), (op == OP_LW): begin
                u.src_int = 2'b01;
                u.dst     = instr[20:16];
                u.dst_v   = 1'b1;
            end
            (op == OP_LWC1): begin
                u.src_int = 2'b01;
                u.dst     = instr[20:16];
                u.dst_fp  = 1'b1;
                u.dst_v   = 1'b1;
            end
            (op == OP_SWC1): begin
                u.src_int = 2'b01;
                u.src_fp  = 2'b10;
            end
            (op == OP_FPR): begin
                u.src_fp = 2'b11;
                u.dst    = instr[10:6];
                u.dst_fp = 1'b1;
                u.dst_v  = 1'b1;
            end
            default: u = '0;
        endcase
        // int $0 is hardwired, so writing it never creates a hazard
        if (!u.dst_fp && (u.dst == 5'd0)) begin
            u.dst_v = 1'b0;
        end
        return u;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// F/D issue-control bundle between decode and the hazard
// controller.
interface id_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      instr_fd;
    logic             valid_fd;
    logic             branch_taken;
    logic             jump_dx;
    logic             stall_fd;
    logic             bubble_dx;
    logic             flush_fd;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output instr_fd, valid_fd, branch_taken, jump_dx,
        input  stall_fd, bubble_dx, flush_fd, mul_busy,
        input  stall_cycles
    );

    modport slave (
        input  instr_fd, valid_fd, branch_taken, jump_dx,
        output stall_fd, bubble_dx, flush_fd, mul_busy,
        output stall_cycles
    );
endinterface

// File: rtl/id_reg_use_dec.sv
// Combinational field and register-usage decode of the F/D
// instruction.
module id_reg_use_dec
    import id_hazard_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output reg_use_t    use_r,
    output logic        is_load,
    output logic        is_fpr,
    output logic        is_mul
);

    logic [5:0] op;

    assign op      = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign use_r   = decode_use(instr);
    assign is_load = (op == OP_LW) | (op == OP_LWC1);
    assign is_fpr  = (op == OP_FPR);
    assign is_mul  = is_fpr & (instr[5:0] == FN_MUL_S);

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: load-use and MUL.S hazards,
// flush priority and a saturating stall counter.
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             rstn,
    id_hazard_ctrl_if.slave hz
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    logic [4:0] rs, rt, fs;
    reg_use_t   use_fd;
    logic       is_load, is_fpr, is_mul;

    mul_state_e state, state_nxt;
    logic [3:0] mul_cnt, mul_cnt_nxt;
    logic [4:0] mul_dst, mul_dst_nxt;
    logic       ld_v, ld_fp;
    logic [4:0] ld_dst;
    logic [CNT_W-1:0] stall_cnt;

    logic ld_rd_int, ld_rd_fp, ld_hz;
    logic mul_rd, mul_wr, mul_hz;
    logic flush, stall, issue;

    id_reg_use_dec u_dec (
        .instr   (hz.instr_fd),
        .rs      (rs),
        .rt      (rt),
        .rd      (fs),
        .use_r   (use_fd),
        .is_load (is_load),
        .is_fpr  (is_fpr),
        .is_mul  (is_mul)
    );

    assign ld_rd_int = (use_fd.src_int[0] & (rs == ld_dst))
                     | (use_fd.src_int[1] & (rt == ld_dst));
    assign ld_rd_fp  = (use_fd.src_fp[0] & (fs == ld_dst))
                     | (use_fd.src_fp[1] & (rt == ld_dst));
    assign ld_hz     = ld_v & (ld_fp ? ld_rd_fp : ld_rd_int);

    assign mul_rd = (use_fd.src_fp[0] & (fs == mul_dst))
                  | (use_fd.src_fp[1] & (rt == mul_dst));
    assign mul_wr = use_fd.dst_v & use_fd.dst_fp
                  & (use_fd.dst == mul_dst);
    assign mul_hz = (state == MUL_BUSY)
                  & (is_fpr | mul_rd | mul_wr);

    assign flush = hz.branch_taken | hz.jump_dx;
    assign stall = hz.valid_fd & (ld_hz | mul_hz) & ~flush;
    assign issue = hz.valid_fd & ~stall & ~flush;

    assign hz.stall_fd     = stall;
    assign hz.flush_fd     = flush;
    assign hz.bubble_dx    = stall | flush;
    assign hz.mul_busy     = (state == MUL_BUSY);
    assign hz.stall_cycles = stall_cnt;

    // MUL.S tracking: next state, countdown and destination latch
    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        mul_dst_nxt = mul_dst;
        unique case (state)
            IDLE: begin
                if (issue && is_mul) begin
                    state_nxt   = MUL_BUSY;
                    mul_cnt_nxt = MUL_INIT;
                    mul_dst_nxt = use_fd.dst;
                end
            end
            MUL_BUSY: begin
                mul_cnt_nxt = mul_cnt - 4'd1;
                if (mul_cnt == 4'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // MUL FSM register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            mul_cnt <= 4'd0;
            mul_dst <= 5'd0;
        end else begin
            state   <= state_nxt;
            mul_cnt <= mul_cnt_nxt;
            mul_dst <= mul_dst_nxt;
        end
    end

    // last-issued load; cleared by any cycle that does not issue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_v   <= 1'b0;
            ld_fp  <= 1'b0;
            ld_dst <= 5'd0;
        end else if (issue) begin
            ld_v   <= is_load & use_fd.dst_v;
            ld_fp  <= use_fd.dst_fp;
            ld_dst <= use_fd.dst;
        end else begin
            ld_v <= 1'b0;
        end
    end

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed vector bench for id_hazard_ctrl, with a narrow-counter
// second instance for saturation.
module tb_id_hazard_ctrl;

    logic clk;
    logic rstn;

    id_hazard_ctrl_if #(.CNT_W(16)) m_if ();
    id_hazard_ctrl_if #(.CNT_W(2))  s_if ();

    assign s_if.instr_fd     = m_if.instr_fd;
    assign s_if.valid_fd     = m_if.valid_fd;
    assign s_if.branch_taken = m_if.branch_taken;
    assign s_if.jump_dx      = m_if.jump_dx;

    id_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .hz   (m_if)
    );

    id_hazard_ctrl #(.MUL_LAT(4), .CNT_W(2)) dut_sat (
        .clk  (clk),
        .rstn (rstn),
        .hz   (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        v;
        logic        br;
        logic        j;
        logic        st;
        logic        bb;
        logic        fl;
        logic        bz;
        int          cnt;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] enc_i(
        input logic [5:0] op, input logic [4:0] rs,
        input logic [4:0] rt);
        return {op, rs, rt, 16'd0};
    endfunction

    function automatic logic [31:0] enc_r(
        input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'd32};
    endfunction

    function automatic logic [31:0] enc_f(
        input logic [5:0] fn, input logic [4:0] ft,
        input logic [4:0] fs, input logic [4:0] fd);
        return {6'd17, 5'd16, ft, fs, fd, fn};
    endfunction

    task automatic add(input logic [31:0] instr,
                       input logic v, input logic br, input logic j,
                       input logic st, input logic bb, input logic fl,
                       input logic bz, input int cnt);
        vec_t r;
        r.instr = instr; r.v = v; r.br = br; r.j = j;
        r.st = st; r.bb = bb; r.fl = fl; r.bz = bz; r.cnt = cnt;
        tv.push_back(r);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic v,
                         input logic br, input logic j);
        m_if.instr_fd     = instr;
        m_if.valid_fd     = v;
        m_if.branch_taken = br;
        m_if.jump_dx      = j;
    endtask

    task automatic chk_all(input string nm, input int st,
                           input int bb, input int fl, input int bz,
                           input int cnt);
        int sat;
        sat = (cnt > 3) ? 3 : cnt;
        chk({nm, ".stall_fd"},  int'(m_if.stall_fd),     st);
        chk({nm, ".bubble_dx"}, int'(m_if.bubble_dx),    bb);
        chk({nm, ".flush_fd"},  int'(m_if.flush_fd),     fl);
        chk({nm, ".mul_busy"},  int'(m_if.mul_busy),     bz);
        chk({nm, ".stall_cyc"}, int'(m_if.stall_cycles), cnt);
        chk({nm, ".sat_cyc"},   int'(s_if.stall_cycles), sat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] lw5, add652, lw0, add602, lwc3, adds, addi;
        logic [31:0] add333, mul, swc2, adds_ind, lwc2, adds_f2;
        logic [31:0] lw9, beq9, add199;
        lw5      = enc_i(6'd35, 5'd1, 5'd5);
        add652   = enc_r(5'd5, 5'd2, 5'd6);
        lw0      = enc_i(6'd35, 5'd1, 5'd0);
        add602   = enc_r(5'd0, 5'd2, 5'd6);
        lwc3     = enc_i(6'd49, 5'd1, 5'd3);
        adds     = enc_f(6'd0, 5'd1, 5'd3, 5'd4);
        add333   = enc_r(5'd3, 5'd3, 5'd3);
        mul      = enc_f(6'd2, 5'd1, 5'd0, 5'd2);
        swc2     = enc_i(6'd57, 5'd1, 5'd2);
        addi     = enc_i(6'd8, 5'd1, 5'd7);
        adds_ind = enc_f(6'd0, 5'd7, 5'd6, 5'd5);
        lwc2     = enc_i(6'd49, 5'd1, 5'd2);
        adds_f2  = enc_f(6'd0, 5'd1, 5'd2, 5'd4);
        lw9      = enc_i(6'd35, 5'd0, 5'd9);
        beq9     = enc_i(6'd4, 5'd0, 5'd9);
        add199   = enc_r(5'd9, 5'd9, 5'd1);

        //   instr     v  br j   st bb fl bz cnt
        add(32'd0,    0, 0, 0,  0, 0, 0, 0, 0);
        add(lw5,      1, 0, 0,  0, 0, 0, 0, 0);
        add(add652,   1, 0, 0,  1, 1, 0, 0, 0);
        add(add652,   1, 0, 0,  0, 0, 0, 0, 1);
        add(lw0,      1, 0, 0,  0, 0, 0, 0, 1);
        add(add602,   1, 0, 0,  0, 0, 0, 0, 1);
        add(lwc3,     1, 0, 0,  0, 0, 0, 0, 1);
        add(adds,     1, 0, 0,  1, 1, 0, 0, 1);
        add(adds,     1, 0, 0,  0, 0, 0, 0, 2);
        add(lwc3,     1, 0, 0,  0, 0, 0, 0, 2);
        add(add333,   1, 0, 0,  0, 0, 0, 0, 2);
        add(mul,      1, 0, 0,  0, 0, 0, 0, 2);
        add(swc2,     1, 0, 0,  1, 1, 0, 1, 2);
        add(swc2,     1, 0, 0,  1, 1, 0, 1, 3);
        add(swc2,     1, 0, 0,  1, 1, 0, 1, 4);
        add(swc2,     1, 0, 0,  0, 0, 0, 0, 5);
        add(mul,      1, 0, 0,  0, 0, 0, 0, 5);
        add(addi,     1, 0, 0,  0, 0, 0, 1, 5);
        add(adds_ind, 1, 0, 0,  1, 1, 0, 1, 5);
        add(adds_ind, 1, 0, 0,  1, 1, 0, 1, 6);
        add(adds_ind, 1, 0, 0,  0, 0, 0, 0, 7);
        add(mul,      1, 0, 0,  0, 0, 0, 0, 7);
        add(lwc2,     1, 0, 0,  1, 1, 0, 1, 7);
        add(lwc2,     1, 0, 0,  1, 1, 0, 1, 8);
        add(lwc2,     1, 0, 0,  1, 1, 0, 1, 9);
        add(lwc2,     1, 0, 0,  0, 0, 0, 0, 10);
        add(adds_f2,  1, 1, 0,  0, 1, 1, 0, 10);
        add(adds_f2,  1, 0, 0,  0, 0, 0, 0, 10);
        add(mul,      1, 0, 1,  0, 1, 1, 0, 10);
        add(32'd0,    0, 0, 0,  0, 0, 0, 0, 10);
        add(lw9,      1, 0, 0,  0, 0, 0, 0, 10);
        add(beq9,     1, 0, 0,  1, 1, 0, 0, 10);
        add(beq9,     1, 0, 0,  0, 0, 0, 0, 11);
        add(lw9,      1, 0, 0,  0, 0, 0, 0, 11);
        add(add199,   0, 0, 0,  0, 0, 0, 0, 11);
        add(add199,   1, 0, 0,  0, 0, 0, 0, 11);

        rstn = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1 chk_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].instr, tv[i].v, tv[i].br, tv[i].j);
            #1 chk_all($sformatf("vec%0d", i), int'(tv[i].st),
                       int'(tv[i].bb), int'(tv[i].fl),
                       int'(tv[i].bz), tv[i].cnt);
        end

        @(negedge clk);
        drive(mul, 1'b1, 1'b0, 1'b0);
        #1 chk_all("rm_mul", 0, 0, 0, 0, 11);
        @(negedge clk);
        drive(swc2, 1'b1, 1'b0, 1'b0);
        #1 chk_all("rm_busy1", 1, 1, 0, 1, 11);
        @(negedge clk);
        #1 chk_all("rm_busy2", 1, 1, 0, 1, 12);
        #1 rstn = 1'b0;
        #1 chk_all("rm_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(adds_f2, 1'b1, 1'b0, 1'b0);
        #1 chk_all("rm_dep", 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_all("rm_after", 0, 0, 0, 0, 0);

        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(lw5, 1'b1, 1'b0, 1'b0);
            #1 chk_all($sformatf("sat_lw%0d", k), 0, 0, 0, 0, k);
            @(negedge clk);
            drive(add652, 1'b1, 1'b0, 1'b0);
            #1 chk_all($sformatf("sat_add%0d", k), 1, 1, 0, 0, k);
        end
        @(negedge clk);
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_all("sat_end", 0, 0, 0, 0, 5);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
